kdtree_stream_loader: RTL and testbench

Accelerator-side receiver for the host KD-tree load stream. After a `load_kdtree` pulse, it drains the 11-bit input FIFO in the fixed host order: 63 internal nodes of 2 words each, then 64 leaves of 8 patches of 6 words each. It assembles the words into node records and leaf-patch records, writes them to the node and leaf memories, and pulses `load_done` when the tree is fully resident. The block sits between the input FIFO (write side driven from the chip pins) and the node/leaf SRAM wrappers.

---
 rtl/kdtree_stream_loader.sv | 140 ++++++++++++++
 tb/tb_kdtree_stream_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/kdtree_stream_loader.sv
// Receives the host KD-tree load stream from a FWFT FIFO and writes node
// records and leaf-patch records into the node and leaf memories.
module kdtree_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_NODES  = NUM_LEAVES - 1,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
) (
  input  logic                             io_clk,
  input  logic                             io_rst_n,
  input  logic                             load_kdtree,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             fifo_rempty_n,
  output logic                             fifo_deq,
  output logic                             node_wen,
  output logic [ADDR_WIDTH-1:0]            node_waddr,
  output logic [2*DATA_WIDTH-1:0]          node_wdata,
  output logic                             leaf_wen,
  output logic [ADDR_WIDTH-1:0]            leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]     leaf_slot,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata,
  output logic [DATA_WIDTH-1:0]            leaf_widx,
  output logic                             busy,
  output logic                             load_done
);

  localparam int SW  = $clog2(LEAF_SIZE);
  localparam int WCW = $clog2(PATCH_SIZE + 1);

  typedef enum logic [1:0] {IDLE, NODE, LEAF, DONE} state_t;

  state_t                         state, state_nxt;
  logic [WCW-1:0]                 word_cnt;
  logic [ADDR_WIDTH-1:0]          node_cnt;
  logic [ADDR_WIDTH-1:0]          leaf_cnt;
  logic [SW-1:0]                  slot_cnt;
  logic [DATA_WIDTH-1:0]          split_idx;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] patch;

  logic node_last_word, leaf_last_word;

  assign node_last_word = fifo_deq && (state == NODE) && (word_cnt == WCW'(1));
  assign leaf_last_word = fifo_deq && (state == LEAF) && (word_cnt == WCW'(PATCH_SIZE));

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_kdtree) state_nxt = NODE;
      NODE: if (node_last_word && node_cnt == ADDR_WIDTH'(NUM_NODES - 1)) state_nxt = LEAF;
      LEAF: if (leaf_last_word && slot_cnt == SW'(LEAF_SIZE - 1)
                && leaf_cnt == ADDR_WIDTH'(NUM_LEAVES - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_deq  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state)
      NODE, LEAF: begin
        fifo_deq = fifo_rempty_n;
        busy     = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      word_cnt   <= '0;
      node_cnt   <= '0;
      leaf_cnt   <= '0;
      slot_cnt   <= '0;
      split_idx  <= '0;
      patch      <= '0;
      node_wen   <= 1'b0;
      node_waddr <= '0;
      node_wdata <= '0;
      leaf_wen   <= 1'b0;
      leaf_waddr <= '0;
      leaf_slot  <= '0;
      leaf_wdata <= '0;
      leaf_widx  <= '0;
    end else begin
      node_wen <= 1'b0;
      leaf_wen <= 1'b0;
      if (state == IDLE && load_kdtree) begin
        word_cnt <= '0;
        node_cnt <= '0;
        leaf_cnt <= '0;
        slot_cnt <= '0;
      end else if (fifo_deq && state == NODE) begin
        if (word_cnt == '0) begin
          split_idx <= fifo_rdata;
          word_cnt  <= WCW'(1);
        end else begin
          node_wen   <= 1'b1;
          node_waddr <= node_cnt;
          node_wdata <= {fifo_rdata, split_idx};
          node_cnt   <= node_cnt + 1'b1;
          word_cnt   <= '0;
        end
      end else if (fifo_deq && state == LEAF) begin
        if (leaf_last_word) begin
          // the last data word was captured into patch on the previous word
          leaf_wen   <= 1'b1;
          leaf_waddr <= leaf_cnt;
          leaf_slot  <= slot_cnt;
          leaf_wdata <= patch;
          leaf_widx  <= fifo_rdata;
          word_cnt   <= '0;
          if (slot_cnt == SW'(LEAF_SIZE - 1)) begin
            slot_cnt <= '0;
            leaf_cnt <= leaf_cnt + 1'b1;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end else begin
          for (int unsigned k = 0; k < PATCH_SIZE; k++)
            if (word_cnt == WCW'(k)) patch[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kdtree_stream_loader.sv
// Directed bench for kdtree_stream_loader: full, bursty, spurious-start and
// mid-load-reset loads checked against a stream-derived write model.
module tb_kdtree_stream_loader;

  localparam int DW     = 11;
  localparam int NWORDS = 3198;

  logic          io_clk = 1'b0;
  logic          io_rst_n;
  logic          load_kdtree;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty_n;
  logic          fifo_deq;
  logic          node_wen;
  logic [5:0]    node_waddr;
  logic [21:0]   node_wdata;
  logic          leaf_wen;
  logic [5:0]    leaf_waddr;
  logic [2:0]    leaf_slot;
  logic [54:0]   leaf_wdata;
  logic [DW-1:0] leaf_widx;
  logic          busy;
  logic          load_done;

  int total = 0;
  int bad   = 0;

  kdtree_stream_loader #(
    .DATA_WIDTH(11), .LEAF_SIZE(8), .PATCH_SIZE(5), .NUM_LEAVES(64)
  ) dut (
    .io_clk(io_clk), .io_rst_n(io_rst_n), .load_kdtree(load_kdtree),
    .fifo_rdata(fifo_rdata), .fifo_rempty_n(fifo_rempty_n), .fifo_deq(fifo_deq),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_wdata(node_wdata),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_slot(leaf_slot),
    .leaf_wdata(leaf_wdata), .leaf_widx(leaf_widx), .busy(busy), .load_done(load_done)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input int base, input int i);
    return DW'(base + i);
  endfunction

  function automatic logic [54:0] exp_patch(input int base, input int rec);
    logic [54:0] p;
    int st;
    st = 126 + rec * 6;
    for (int k = 0; k < 5; k++) p[k*DW +: DW] = w(base, st + k);
    return p;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_deq"},   fifo_deq, 0);
    check({tag, "_nwen"},  node_wen, 0);
    check({tag, "_lwen"},  leaf_wen, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  load_done, 0);
    check({tag, "_naddr"}, {node_waddr, node_wdata}, 0);
    check({tag, "_laddr"}, {leaf_waddr, leaf_slot, leaf_widx}, 0);
    check({tag, "_ldata"}, leaf_wdata, 0);
  endtask

  task automatic run_load(input int base, input bit bursty, input bit spurious, input int rst_at_lw);
    int ptr = 0, nw = 0, lw = 0, deqs = 0, dones = 0;
    int done_iter = -1, last_node_iter = 0, first_leaf_iter = 0;
    bit aborted = 0, spur_done = 0;
    @(negedge io_clk);
    load_kdtree   = 1'b1;
    fifo_rempty_n = 1'b0;
    fifo_rdata    = '0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_deq", fifo_deq, 0);
    for (int it = 1; it < 20000; it++) begin
      @(negedge io_clk);
      load_kdtree = 1'b0;
      if (spurious && !spur_done && lw == 100) begin
        load_kdtree = 1'b1;
        spur_done   = 1;
      end
      fifo_rempty_n = bursty ? ($urandom_range(0, 3) != 0) : 1'b1;
      fifo_rdata    = (ptr < NWORDS) ? w(base, ptr) : '0;
      #1;
      if (it == 1) check("start_busy", busy, 1);
      if (!fifo_rempty_n) check("deq_when_empty", fifo_deq, 0);
      if (fifo_deq) begin
        ptr++;
        deqs++;
      end
      if (node_wen) begin
        check("wen_excl", leaf_wen, 0);
        check("node_addr", node_waddr, nw);
        check("node_data", node_wdata, {w(base, 2*nw+1), w(base, 2*nw)});
        if (base == 0 && nw == 0)  check("node0_hand", node_wdata, {11'd1, 11'd0});
        if (base == 0 && nw == 62) check("node62_hand", node_wdata, {11'd125, 11'd124});
        last_node_iter = it;
        nw++;
      end
      if (leaf_wen) begin
        check("leaf_addr", leaf_waddr, lw / 8);
        check("leaf_slot", leaf_slot, lw % 8);
        check("leaf_data", leaf_wdata, exp_patch(base, lw));
        check("leaf_idx", leaf_widx, w(base, 126 + lw*6 + 5));
        if (base == 0 && lw == 0) begin
          check("leaf0_data_hand", leaf_wdata, {11'd130, 11'd129, 11'd128, 11'd127, 11'd126});
          check("leaf0_idx_hand", leaf_widx, 131);
        end
        if (base == 0 && lw == 511) check("leaf63s7_idx_hand", leaf_widx, 3197 % 2048);
        if (lw == 0) first_leaf_iter = it;
        lw++;
      end
      if (load_done) begin
        dones++;
        check("done_with_leaf", leaf_wen, 1);
        check("done_busy", busy, 1);
        done_iter = it;
      end
      if (done_iter > 0 && it == done_iter + 1) begin
        check("busy_drop", busy, 0);
        check("done_pulse", load_done, 0);
      end
      if (done_iter > 0 && it == done_iter + 3) break;
      if (rst_at_lw > 0 && lw == rst_at_lw) begin
        io_rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        @(negedge io_clk);
        check("midrst_hold_deq", fifo_deq, 0);
        io_rst_n = 1'b1;
        aborted  = 1;
        break;
      end
    end
    load_kdtree = 1'b0;
    if (!aborted) begin
      check("cnt_deq", deqs, NWORDS);
      check("cnt_node", nw, 63);
      check("cnt_leaf", lw, 512);
      check("cnt_done", dones, 1);
      if (!bursty) begin
        check("done_latency", done_iter, 3199);
        check("node_leaf_gap", first_leaf_iter - last_node_iter, 6);
      end
    end
  endtask

  initial begin
    io_rst_n      = 1'b0;
    load_kdtree   = 1'b0;
    fifo_rempty_n = 1'b1;
    fifo_rdata    = 11'h5a5;
    repeat (3) @(negedge io_clk);
    check_cleared("reset");
    io_rst_n = 1'b1;
    repeat (3) @(negedge io_clk);
    #1;
    check("idle_no_deq", fifo_deq, 0);
    check("idle_not_busy", busy, 0);

    run_load(0, 1'b0, 1'b0, 0);
    run_load(7, 1'b1, 1'b0, 0);
    run_load(3, 1'b0, 1'b1, 0);
    run_load(9, 1'b0, 1'b0, 80);
    run_load(500, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
